// File: rtl/servo_pkg.sv
// servo_pkg: shared direction codes, sequencer state encoding and counter sizing
package servo_pkg;

    localparam logic [2:0] DIR_STOP  = 3'b000;
    localparam logic [2:0] DIR_FWD   = 3'b001;
    localparam logic [2:0] DIR_BACK  = 3'b010;
    localparam logic [2:0] DIR_LEFT  = 3'b011;
    localparam logic [2:0] DIR_RIGHT = 3'b100;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_LOAD,
        SEQ_RUN,
        SEQ_GAP
    } seq_state_e;

    // ms counter must hold both the longest move and the stop interval
    function automatic int ms_cnt_w(input int dur_w, input int gap_ms);
        return (dur_w > $clog2(gap_ms + 1)) ? dur_w : $clog2(gap_ms + 1);
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: synchronous command queue of {dir, ms} entries with flush
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 15
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [CW-1:0] cnt_q;
    logic          push_ok;
    logic          pop_ok;

    assign full    = cnt_q == CW'(DEPTH);
    assign empty   = cnt_q == '0;
    assign count   = cnt_q;
    assign dout    = mem_q[rd_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // pointers and occupancy; flush wins over any same-cycle push or pop
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_ok) wr_q <= wr_q + AW'(1);
            if (pop_ok) rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // storage needs no reset; only occupied slots are ever read
    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem_q[wr_q] <= din;
    end

endmodule

// File: rtl/servo_move_sequencer.sv
// servo_move_sequencer: replays queued timed moves on the servo controller with stop gaps
module servo_move_sequencer
    import servo_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int FIFO_DEPTH  = 4,
    parameter int DUR_W       = 12,
    parameter int GAP_MS      = 20
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [2:0]                    cmd_dir,
    input  logic [DUR_W-1:0]              cmd_ms,
    input  logic                          abort,
    output logic [2:0]                    direction,
    output logic                          use_servo,
    output logic                          busy,
    output logic                          seq_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int TPM   = CLK_FREQ_HZ / 1000;
    localparam int PRE_W = ($clog2(TPM) > 0) ? $clog2(TPM) : 1;
    localparam int MS_W  = ms_cnt_w(DUR_W, GAP_MS);
    localparam int ENT_W = 3 + DUR_W;

    seq_state_e       state_q, state_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [MS_W-1:0]  ms_q, ms_d;
    logic [DUR_W-1:0] cur_ms_q, cur_ms_d;
    logic [2:0]       dir_q, dir_d;
    logic             use_servo_q, use_servo_d;
    logic             seq_done_q, seq_done_d;

    logic             push, pop, flush, full, empty;
    logic [2:0]       push_dir;
    logic [ENT_W-1:0] head;
    logic [2:0]       head_dir;
    logic [DUR_W-1:0] head_ms;
    logic             ms_tick, run_end, gap_end;

    assign cmd_ready = !full && !abort;
    assign push      = cmd_valid && cmd_ready;
    assign push_dir  = (cmd_dir > DIR_RIGHT) ? DIR_STOP : cmd_dir;
    assign head_dir  = head[DUR_W +: 3];
    assign head_ms   = head[DUR_W-1:0];
    assign ms_tick   = pre_q == PRE_W'(TPM - 1);
    assign run_end   = ms_tick && (ms_q == MS_W'(cur_ms_q) - MS_W'(1));
    assign gap_end   = ms_tick && (ms_q == MS_W'(GAP_MS - 1));

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (ENT_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .flush   (flush),
        .din     ({push_dir, cmd_ms}),
        .dout    (head),
        .full    (full),
        .empty   (empty),
        .count   (fifo_count)
    );

    // state, timing counters and registered servo-side outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= SEQ_IDLE;
            pre_q       <= '0;
            ms_q        <= '0;
            cur_ms_q    <= '0;
            dir_q       <= DIR_STOP;
            use_servo_q <= 1'b0;
            seq_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pre_q       <= pre_d;
            ms_q        <= ms_d;
            cur_ms_q    <= cur_ms_d;
            dir_q       <= dir_d;
            use_servo_q <= use_servo_d;
            seq_done_q  <= seq_done_d;
        end
    end

    // sequencing: load head, time the move, time the stop gap; abort overrides all
    always_comb begin
        state_d     = state_q;
        pre_d       = pre_q;
        ms_d        = ms_q;
        cur_ms_d    = cur_ms_q;
        dir_d       = dir_q;
        use_servo_d = 1'b0;
        seq_done_d  = 1'b0;
        pop         = 1'b0;
        flush       = 1'b0;
        if (abort) begin
            flush       = 1'b1;
            state_d     = SEQ_IDLE;
            dir_d       = DIR_STOP;
            use_servo_d = state_q != SEQ_IDLE;
            pre_d       = '0;
            ms_d        = '0;
        end else begin
            case (state_q)
                SEQ_IDLE: begin
                    dir_d   = DIR_STOP;
                    state_d = empty ? SEQ_IDLE : SEQ_LOAD;
                end
                SEQ_LOAD: begin
                    pop      = 1'b1;
                    cur_ms_d = head_ms;
                    pre_d    = '0;
                    ms_d     = '0;
                    if (head_ms != '0) begin
                        dir_d       = head_dir;
                        use_servo_d = 1'b1;
                        state_d     = SEQ_RUN;
                    end else begin
                        state_d = SEQ_GAP;
                    end
                end
                SEQ_RUN: begin
                    pre_d = ms_tick ? '0 : pre_q + PRE_W'(1);
                    ms_d  = ms_tick ? ms_q + MS_W'(1) : ms_q;
                    if (run_end) begin
                        dir_d       = DIR_STOP;
                        use_servo_d = 1'b1;
                        pre_d       = '0;
                        ms_d        = '0;
                        state_d     = SEQ_GAP;
                    end
                end
                SEQ_GAP: begin
                    pre_d = ms_tick ? '0 : pre_q + PRE_W'(1);
                    ms_d  = ms_tick ? ms_q + MS_W'(1) : ms_q;
                    if (gap_end) begin
                        pre_d      = '0;
                        ms_d       = '0;
                        seq_done_d = empty;
                        state_d    = empty ? SEQ_IDLE : SEQ_LOAD;
                    end
                end
                default: state_d = SEQ_IDLE;
            endcase
        end
    end

    assign direction = dir_q;
    assign use_servo = use_servo_q;
    assign seq_done  = seq_done_q;
    assign busy      = (state_q != SEQ_IDLE) || !empty;

endmodule

// File: tb/tb_servo_move_sequencer.sv
// tb_servo_move_sequencer: directed scenarios with a scoreboard of expected strobe/done events
module tb_servo_move_sequencer;

    localparam int DW = 12;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    cmd_dir = 3'd0;
    logic [DW-1:0] cmd_ms = '0;
    logic          abort = 1'b0;
    logic [2:0]    direction;
    logic          use_servo;
    logic          busy;
    logic          seq_done;
    logic [2:0]    fifo_count;

    typedef struct {
        bit         done;
        logic [2:0] dir;
        int         at;
    } ev_t;

    ev_t exp_q[$];
    int  errors = 0;
    int  checks = 0;
    int  cyc = 0;

    servo_move_sequencer #(
        .CLK_FREQ_HZ (10_000),
        .FIFO_DEPTH  (4),
        .DUR_W       (DW),
        .GAP_MS      (2)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_dir    (cmd_dir),
        .cmd_ms     (cmd_ms),
        .abort      (abort),
        .direction  (direction),
        .use_servo  (use_servo),
        .busy       (busy),
        .seq_done   (seq_done),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic exp_ev(input bit done, input logic [2:0] dir, input int at);
        exp_q.push_back('{done, dir, at});
    endtask

    task automatic push(input logic [2:0] d, input int ms, output int acc);
        int n = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_dir = d;
        cmd_ms = ms[DW-1:0];
        #1;
        while (!cmd_ready && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!cmd_ready) begin
            chk("push_timeout", 0, 1);
            cmd_valid = 1'b0;
            acc = -1;
            return;
        end
        @(posedge clk);
        #1;
        acc = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // monitor: every strobe or done pulse must match the next expected event
    always @(negedge clk) begin
        if (reset_n && (use_servo || seq_done)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: use_servo=%0b seq_done=%0b dir=%0d expected none (cycle %0d)",
                         use_servo, seq_done, direction, cyc);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                chk("ev_kind_done", int'(seq_done), int'(e.done));
                chk("ev_cycle", cyc, e.at);
                if (!e.done) chk("ev_dir", int'(direction), int'(e.dir));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, b, c, acc5;
        logic [2:0] dirs [5];
        dirs[0] = 3'd2; dirs[1] = 3'd3; dirs[2] = 3'd4; dirs[3] = 3'd1; dirs[4] = 3'd2;

        repeat (3) @(negedge clk);
        chk("rst_direction", int'(direction), 0);
        chk("rst_use_servo", int'(use_servo), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_seq_done", int'(seq_done), 0);
        chk("rst_fifo_count", int'(fifo_count), 0);
        chk("rst_cmd_ready", int'(cmd_ready), 1);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // single command {001, 3}
        push(3'd1, 3, a);
        exp_ev(0, 3'd1, a + 2);
        exp_ev(0, 3'd0, a + 32);
        exp_ev(1, 3'd0, a + 52);
        wait_until(a + 10);
        chk("single_dir_mid_run", int'(direction), 1);
        wait_until(a + 51);
        chk("single_busy_before_done", int'(busy), 1);
        wait_until(a + 52);
        chk("single_busy_at_done", int'(busy), 0);
        wait_until(a + 56);
        chk("single_drained", exp_q.size(), 0);

        // back-to-back {001,2}, {011,1}, {100,1}
        push(3'd1, 2, a);
        push(3'd3, 1, b);
        push(3'd4, 1, c);
        chk("b2b_consecutive_1", b, a + 1);
        chk("b2b_consecutive_2", c, a + 2);
        exp_ev(0, 3'd1, a + 2);
        exp_ev(0, 3'd0, a + 22);
        exp_ev(0, 3'd3, a + 43);
        exp_ev(0, 3'd0, a + 53);
        exp_ev(0, 3'd4, a + 74);
        exp_ev(0, 3'd0, a + 84);
        exp_ev(1, 3'd0, a + 104);
        wait_until(a + 110);
        chk("b2b_drained", exp_q.size(), 0);

        // zero-length then invalid direction
        push(3'd2, 0, a);
        push(3'd7, 1, b);
        exp_ev(0, 3'd0, a + 23);
        exp_ev(0, 3'd0, a + 33);
        exp_ev(1, 3'd0, a + 53);
        chk("zero_count_after_pushes", int'(fifo_count), 2);
        wait_until(a + 10);
        chk("zero_gap_busy", int'(busy), 1);
        chk("zero_gap_dir", int'(direction), 0);
        wait_until(a + 28);
        chk("invalid_dir_runs_as_stop", int'(direction), 0);
        wait_until(a + 58);
        chk("zero_drained", exp_q.size(), 0);

        // full queue: one long move running, then fill and over-offer
        push(3'd1, 4, a);
        exp_ev(0, 3'd1, a + 2);
        exp_ev(0, 3'd0, a + 42);
        for (int k = 0; k < 5; k++) begin
            exp_ev(0, dirs[k], a + 63 + 31 * k);
            exp_ev(0, 3'd0, a + 73 + 31 * k);
        end
        exp_ev(1, 3'd0, a + 217);
        for (int k = 0; k < 4; k++) push(dirs[k], 1, b);
        @(negedge clk);
        chk("full_count", int'(fifo_count), 4);
        cmd_valid = 1'b1;
        cmd_dir = dirs[4];
        cmd_ms = 12'd1;
        #1;
        chk("full_ready_low", int'(cmd_ready), 0);
        push(dirs[4], 1, acc5);
        chk("full_accept_after_pop", acc5, a + 64);
        wait_until(a + 222);
        chk("full_drained", exp_q.size(), 0);

        // abort mid-RUN with two entries queued
        push(3'd1, 5, a);
        push(3'd3, 1, b);
        push(3'd4, 1, c);
        exp_ev(0, 3'd1, a + 2);
        exp_ev(0, 3'd0, a + 11);
        wait_until(a + 10);
        chk("abort_pre_count", int'(fifo_count), 2);
        abort = 1'b1;
        cmd_valid = 1'b1;
        cmd_dir = 3'd4;
        cmd_ms = 12'd1;
        #1;
        chk("abort_ready_low", int'(cmd_ready), 0);
        @(negedge clk);
        abort = 1'b0;
        cmd_valid = 1'b0;
        chk("abort_count_flushed", int'(fifo_count), 0);
        chk("abort_dir_stop", int'(direction), 0);
        chk("abort_idle", int'(busy), 0);
        wait_until(a + 80);
        chk("abort_push_refused", int'(fifo_count), 0);
        chk("abort_stays_idle", int'(busy), 0);
        chk("abort_drained", exp_q.size(), 0);

        // asynchronous reset mid-GAP with one entry queued
        push(3'd1, 1, a);
        push(3'd2, 3, b);
        exp_ev(0, 3'd1, a + 2);
        exp_ev(0, 3'd0, a + 12);
        wait_until(a + 20);
        chk("rgap_count_before", int'(fifo_count), 1);
        reset_n = 1'b0;
        #1;
        chk("rgap_direction", int'(direction), 0);
        chk("rgap_use_servo", int'(use_servo), 0);
        chk("rgap_busy", int'(busy), 0);
        chk("rgap_seq_done", int'(seq_done), 0);
        chk("rgap_fifo_count", int'(fifo_count), 0);
        @(negedge clk);
        reset_n = 1'b1;
        push(3'd4, 2, b);
        exp_ev(0, 3'd4, b + 2);
        exp_ev(0, 3'd0, b + 22);
        exp_ev(1, 3'd0, b + 42);
        wait_until(b + 46);
        chk("post_reset_drained", exp_q.size(), 0);
        chk("post_reset_idle", int'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
